// File: rtl/pmips_dmem_responder_pkg.sv
// Shared constants and address decode for the PMIPS data-memory responder.
package pmips_mem_pkg;

  localparam logic [7:0] IO_PAGE_DFLT = 8'hFF;

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h02;
  localparam logic [7:0] OFF_CYCLE = 8'h04;
  localparam logic [7:0] OFF_TLOAD = 8'h06;
  localparam logic [7:0] OFF_TSTAT = 8'h08;
  localparam logic [7:0] OFF_ERR   = 8'h0A;

  localparam int ST_RUN  = 0;
  localparam int ST_DONE = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } region_e;

  // The I/O page is checked first so it shadows RAM if the two ever overlap.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [7:0]  io_page,
                                            input int          ram_aw);
    if (addr[15:8] == io_page)
      return REGION_IO;
    if ((addr >> (ram_aw + 1)) == 16'd0)
      return REGION_RAM;
    return REGION_UNMAPPED;
  endfunction

endpackage

// File: rtl/pmips_dmem_responder_if.sv
// Data-memory port between the PMIPS core (master) and the memory responder (slave).
interface pmips_dmem_responder_if;

  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (
    output dmemaddr,
    output dmemwdata,
    output dmemwrite,
    output dmemread,
    input  dmemrdata
  );

  modport slave (
    input  dmemaddr,
    input  dmemwdata,
    input  dmemwrite,
    input  dmemread,
    output dmemrdata
  );

endinterface

// File: rtl/pmips_dmem_responder_timer.sv
// Countdown timer for the I/O page: load, decrement while running, sticky done flag.
module pmips_io_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        clr_done_i,
  output logic [15:0] count_o,
  output logic        running_o,
  output logic        done_o
);

  logic [15:0] count_q, count_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        expire;

  assign expire = running_q && (count_q == 16'd1);

  // Later assignments take priority: clear < expiry < load.
  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    done_d    = done_q;
    if (clr_done_i)
      done_d = 1'b0;
    if (running_q)
      count_d = count_q - 16'd1;
    if (expire) begin
      running_d = 1'b0;
      done_d    = 1'b1;
    end
    if (load_i) begin
      count_d   = load_val_i;
      running_d = (load_val_i != 16'd0);
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= 16'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: rtl/pmips_dmem_responder.sv
// PMIPS data-memory responder: word RAM, memory-mapped I/O page, unmapped-access trap.
module pmips_dmem_responder
  import pmips_mem_pkg::*;
#(
  parameter int         RAM_AW  = 7,
  parameter logic [7:0] IO_PAGE = IO_PAGE_DFLT
) (
  input  logic                         clock,
  input  logic                         reset,
  pmips_dmem_responder_if.slave        dmem,
  input  logic [7:0]                   sw,
  output logic [7:0]                   led,
  output logic                         timer_done,
  output logic                         err_unmapped
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  // Read is combinational because the core's MEM stage samples data in the address cycle.
  logic [15:0] mem [RAM_WORDS];

  region_e           region;
  logic [RAM_AW-1:0] word_idx;
  logic [7:0]        io_off;
  logic              io_wr;

  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [15:0] cycle_q, cycle_d;
  logic        err_q, err_d;

  logic [15:0] tmr_count;
  logic        tmr_running;
  logic        tmr_done;
  logic [15:0] io_rdata;

  assign region   = decode_region(dmem.dmemaddr, IO_PAGE, RAM_AW);
  assign word_idx = dmem.dmemaddr[RAM_AW:1];
  assign io_off   = {dmem.dmemaddr[7:1], 1'b0};
  assign io_wr    = dmem.dmemwrite && !reset && (region == REGION_IO);

  always_ff @(posedge clock) begin
    if (!reset && dmem.dmemwrite && (region == REGION_RAM))
      mem[word_idx] <= dmem.dmemwdata;
  end

  pmips_io_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (io_wr && (io_off == OFF_TLOAD)),
    .load_val_i (dmem.dmemwdata),
    .clr_done_i (io_wr && (io_off == OFF_TSTAT) && dmem.dmemwdata[ST_DONE]),
    .count_o    (tmr_count),
    .running_o  (tmr_running),
    .done_o     (tmr_done)
  );

  // An unmapped access in the same cycle as an ERR clear leaves err set.
  always_comb begin
    led_d   = led_q;
    err_d   = err_q;
    cycle_d = cycle_q + 16'd1;
    if (io_wr && (io_off == OFF_LED))
      led_d = dmem.dmemwdata[7:0];
    if (io_wr && (io_off == OFF_ERR) && dmem.dmemwdata[0])
      err_d = 1'b0;
    if ((region == REGION_UNMAPPED) && (dmem.dmemread || dmem.dmemwrite))
      err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= 8'd0;
      sw_meta_q <= 8'd0;
      sw_sync_q <= 8'd0;
      cycle_q   <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      cycle_q   <= cycle_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    io_rdata = 16'd0;
    case (io_off)
      OFF_LED:   io_rdata = {8'h00, led_q};
      OFF_SW:    io_rdata = {8'h00, sw_sync_q};
      OFF_CYCLE: io_rdata = cycle_q;
      OFF_TLOAD: io_rdata = tmr_count;
      OFF_TSTAT: begin
        io_rdata[ST_DONE] = tmr_done;
        io_rdata[ST_RUN]  = tmr_running;
      end
      OFF_ERR:   io_rdata = {15'd0, err_q};
      default:   io_rdata = 16'd0;
    endcase
  end

  always_comb begin
    dmem.dmemrdata = 16'd0;
    if (!reset && dmem.dmemread) begin
      case (region)
        REGION_RAM: dmem.dmemrdata = mem[word_idx];
        REGION_IO:  dmem.dmemrdata = io_rdata;
        default:    dmem.dmemrdata = 16'd0;
      endcase
    end
  end

  assign led          = led_q;
  assign timer_done   = tmr_done;
  assign err_unmapped = err_q;

endmodule

// File: tb/tb_pmips_dmem_responder.sv
// Scoreboard bench for pmips_dmem_responder: table-driven bus cycles, expected read data queued per cycle.
module tb_pmips_dmem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [7:0] sw_next = 8'h00;
  logic [7:0] led;
  logic       timer_done;
  logic       err_unmapped;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] sb_q[$];

  // One bus cycle: reset, address, wdata, write, read, expected rdata, expected {led,timer_done,err}.
  typedef struct packed {
    logic        rst;
    logic [15:0] a;
    logic [15:0] wd;
    logic        w;
    logic        r;
    logic        chk;
    logic [15:0] erd;
    logic        fchk;
    logic [9:0]  eflg;
  } step_t;

  pmips_dmem_responder_if dmem();

  pmips_dmem_responder #(.RAM_AW(7), .IO_PAGE(8'hFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .dmem         (dmem.slave),
    .sw           (sw),
    .led          (led),
    .timer_done   (timer_done),
    .err_unmapped (err_unmapped)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic rst, input logic [15:0] a, input logic [15:0] wd,
                       input logic w, input logic r);
    @(negedge clock);
    reset          = rst;
    sw             = sw_next;
    dmem.dmemaddr  = a;
    dmem.dmemwdata = wd;
    dmem.dmemwrite = w;
    dmem.dmemread  = r;
    #2;
  endtask

  task automatic test_reset();
    step_t s[5];
    logic [15:0] e;
    s = '{'{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b1, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF04, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF0A, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL reset[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("reset[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL reset_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ram();
    step_t s[8];
    logic [15:0] e;
    s = '{'{1'b0, 16'h0010, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 10'h000},
          '{1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 10'h000},
          '{1'b0, 16'h0010, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 10'h000},
          '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 10'h000},
          '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'h00FE, 16'hCAFE, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'h00FE, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hCAFE, 1'b1, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL ram[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("ram[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL ram_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_led_reset();
    step_t s[5];
    logic [15:0] e;
    s = '{'{1'b0, 16'hFF00, 16'h00A5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A5, 1'b1, 10'h294},
          '{1'b1, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h294},
          '{1'b0, 16'hFF04, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF04, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL led[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("led[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL led_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sw_sync();
    logic [15:0] exp_tbl[3] = '{16'h0000, 16'h0000, 16'h003C};
    logic [15:0] e;
    sw_next = 8'h3C;
    foreach (exp_tbl[i]) begin
      drive(1'b0, 16'hFF02, 16'h0000, 1'b0, 1'b1);
      sb_q.push_back(exp_tbl[i]);
      e = sb_q.pop_front();
      n_total++;
      if (dmem.dmemrdata !== e) $display("FAIL sw_sync cycle N+%0d rdata=%h expected=%h", i, dmem.dmemrdata, e);
      else begin n_pass++; $display("sw_sync cycle N+%0d rdata=%h ok", i, dmem.dmemrdata); end
    end
  endtask

  task automatic test_cycle_wrap();
    logic [15:0] e;
    drive(1'b1, 16'hFF04, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 16'hFF04, 16'h0000, 1'b0, 1'b1);
    sb_q.push_back(16'h0000);
    e = sb_q.pop_front();
    n_total++;
    if (dmem.dmemrdata !== e) $display("FAIL cycle_start rdata=%h expected=%h", dmem.dmemrdata, e);
    else begin n_pass++; $display("cycle_start rdata=%h ok", dmem.dmemrdata); end
    repeat (65535) @(negedge clock);
    #2;
    sb_q.push_back(16'hFFFF);
    e = sb_q.pop_front();
    n_total++;
    if (dmem.dmemrdata !== e) $display("FAIL cycle_max rdata=%h expected=%h", dmem.dmemrdata, e);
    else begin n_pass++; $display("cycle_max rdata=%h ok", dmem.dmemrdata); end
    @(negedge clock);
    #2;
    sb_q.push_back(16'h0000);
    e = sb_q.pop_front();
    n_total++;
    if (dmem.dmemrdata !== e) $display("FAIL cycle_wrap rdata=%h expected=%h", dmem.dmemrdata, e);
    else begin n_pass++; $display("cycle_wrap rdata=%h ok", dmem.dmemrdata); end
  endtask

  task automatic test_timer();
    step_t s[11];
    logic [15:0] e;
    s = '{'{1'b0, 16'hFF06, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 10'h002},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL timer[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("timer[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL timer_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timer_precedence();
    step_t s[10];
    logic [15:0] e;
    s = '{'{1'b0, 16'hFF06, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 10'h002}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL tprec[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("tprec[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL tprec_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_unmapped();
    step_t s[8];
    logic [15:0] e;
    s = '{'{1'b0, 16'hFF08, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF0A, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 10'h001},
          '{1'b0, 16'h0110, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF0A, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h001},
          '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 10'h000},
          '{1'b0, 16'hFF0E, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF0A, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL unmapped[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("unmapped[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL unmapped_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_timer();
    step_t s[6];
    logic [15:0] e;
    s = '{'{1'b0, 16'hFF06, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h000A, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 10'h000},
          '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'h000},
          '{1'b0, 16'hFF08, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000},
          '{1'b0, 16'hFF06, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 10'h000}};
    foreach (s[i]) begin
      drive(s[i].rst, s[i].a, s[i].wd, s[i].w, s[i].r);
      if (s[i].chk) begin
        sb_q.push_back(s[i].erd);
        e = sb_q.pop_front();
        n_total++;
        if (dmem.dmemrdata !== e) $display("FAIL rst_timer[%0d] addr=%h rdata=%h expected=%h", i, s[i].a, dmem.dmemrdata, e);
        else begin n_pass++; $display("rst_timer[%0d] addr=%h rdata=%h ok", i, s[i].a, dmem.dmemrdata); end
      end
      if (s[i].fchk) begin
        n_total++;
        if ({led, timer_done, err_unmapped} !== s[i].eflg) $display("FAIL rst_timer_flags[%0d] flags=%h expected=%h", i, {led, timer_done, err_unmapped}, s[i].eflg);
        else n_pass++;
      end
    end
  endtask

  initial begin
    dmem.dmemaddr  = 16'h0000;
    dmem.dmemwdata = 16'h0000;
    dmem.dmemwrite = 1'b0;
    dmem.dmemread  = 1'b0;
    test_reset();
    test_ram();
    test_led_reset();
    test_sw_sync();
    test_cycle_wrap();
    test_timer();
    test_timer_precedence();
    test_unmapped();
    test_reset_mid_timer();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pmips_dmem_responder.md
Name: pmips_dmem_responder

Overview:
Responder on the PMIPS data-memory port. It consumes the core's dmemaddr, dmemwdata, dmemwrite and dmemread, and drives dmemrdata back to the core. Requests are decoded into three regions: a word RAM, a memory-mapped I/O page (LEDs, switches, cycle counter, countdown timer, error status) and unmapped space. It sits beside the core at top level on the Spartan-3E board, and the core's MEM stage samples dmemrdata in the same cycle it presents the address.

Parameters:
RAM_AW, 7, word-address width of RAM (RAM size is 2^RAM_AW 16-bit words, byte range 0 to 2^(RAM_AW+1)-1)
IO_PAGE, 8'hFF, dmemaddr[15:8] value that selects the I/O page

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
dmemaddr  in  16  byte address from core; bit 0 ignored (word access only)
dmemwdata  in  16  write data from core
dmemwrite  in  1  write enable, sampled at rising edge
dmemread  in  1  read enable
dmemrdata  out  16  read data, combinational, same cycle as address
sw  in  8  board switches, asynchronous
led  out  8  board LEDs
timer_done  out  1  sticky timer-expired flag (mirror of STAT bit1)
err_unmapped  out  1  sticky unmapped-access flag

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. While reset=1, all registers clear: led=0, sw sync flops=0, CYCLE=0, timer count=0, running=0, done=0, err=0. dmemrdata is forced to 0 while reset=1. Writes are ignored while reset=1. RAM contents are not cleared.
- Decode order: dmemaddr[15:8]==IO_PAGE selects I/O. Otherwise dmemaddr < 2^(RAM_AW+1) selects RAM. Otherwise the access is unmapped.
- Read data: dmemrdata=0 whenever dmemread=0.
- RAM read: dmemrdata = mem[dmemaddr[RAM_AW:1]], zero latency.
- RAM write: mem is written at the rising edge when dmemwrite=1.
- Simultaneous read and write to the same address: read returns the old data; the new data is visible from the next cycle.
- I/O page, word offsets dmemaddr[7:0]:
  - 0x00 LED, RW: write sets led<=dmemwdata[7:0]; read returns {8'h00, led}.
  - 0x02 SW, RO: two-flop synchroniser of sw; read returns {8'h00, sw_sync}. A change on sw is readable 2 edges later.
  - 0x04 CYCLE, RO: free-running 16-bit up-counter, +1 every cycle, wraps 0xFFFF to 0x0000. Writes are ignored.
  - 0x06 TLOAD: write loads count<=dmemwdata, sets running<=(dmemwdata!=0) and done<=0. Read returns the current count.
  - 0x08 TSTAT: read returns {14'b0, done, running}. A write with dmemwdata[1]=1 clears done; other bits are ignored.
  - 0x0A ERR: read returns {15'b0, err}. A write with dmemwdata[0]=1 clears err.
  - Other offsets in the I/O page: read 0, write ignored. These do not set err.
- Timer, while running=1:
  - count decrements by 1 each cycle.
  - On the edge where count==1, count becomes 0, running becomes 0 and done becomes 1.
  - Precedence: a TLOAD write in the same cycle as expiry wins (new count, done=0). Expiry in the same cycle as a TSTAT clear wins (done=1).
- Unmapped access: reads return 0 and writes are dropped. If (dmemread|dmemwrite)=1, err<=1 at the edge. A set in the same cycle as an ERR clear wins (err=1).
- No back-pressure: every access completes in one cycle. Reads have no side effects.

Decomposition:
- Shared package pmips_mem_pkg:
  - IO offset constants OFF_LED, OFF_SW, OFF_CYCLE, OFF_TLOAD, OFF_TSTAT, OFF_ERR.
  - TSTAT bit indices ST_RUN=0 and ST_DONE=1.
  - Default IO_PAGE.
- One sub-module, pmips_io_timer:
  - Inputs: load strobe, load value, clear-done strobe.
  - Outputs: count, running, done.
- RAM, decode, registers and read mux stay in the top module.

Test Plan:
1. Write 0x1234 to addr 0x0010, then read 0x0010 and 0x0011 -> dmemrdata=0x1234 both times. Simultaneous read+write of 0xBEEF -> old value 0x1234 that cycle, 0xBEEF next cycle.
2. Write 0x00A5 to 0xFF00 -> led=0xA5 after the edge and readback=0x00A5. Apply reset -> led=0, CYCLE read=0.
3. Set sw=0x3C at cycle N -> reads of 0xFF02 return 0x0000 through cycle N+1 and 0x003C from N+2. Hold the CYCLE read over 0x10000 cycles -> observe the wrap from 0xFFFF to 0x0000.
4. Write 3 to 0xFF06 -> count reads 3,2,1; then running=0, done=1, timer_done=1. Write 2 to 0xFF08 -> done=0. Write 0 to 0xFF06 -> running stays 0, done stays 0.
5. Reload 0xFF06 with 5 on the expiry cycle -> done stays 0 and count=5. Write 0x0002 to 0xFF08 on the expiry cycle -> done=1.
6. Read 0x4000 (RAM_AW=7) -> dmemrdata=0 and err_unmapped=1 after the edge. Access 0xFF0E -> err unchanged. Write 1 to 0xFF0A -> err=0. Assert reset mid-timer-run -> count=0, running=0, done=0.
